ibus_arbiter: RTL

- Arbiter and sequencer for the shared 16-bit internal tri-state data bus.
- The bus is driven in turn by the execution unit, the bus interface unit and the register/prefetch side.
- Grants exclusive drive rights to one requester at a time, using rotating round-robin priority.
- Inserts a mandatory idle turnaround between owners so two drivers never overlap, and forcibly revokes ownership held past a hold limit.

---
 rtl/ibus_arbiter_pkg.sv | 30 +++
 rtl/ibus_arbiter_rr_pick.sv | 31 +++
 rtl/ibus_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/ibus_arbiter_pkg.sv
// Shared definitions for the internal data bus arbiter: requester indices,
// state encoding and default timing limits.
package ibus_arbiter_pkg;

  localparam int REQ_EU  = 0;
  localparam int REQ_BIU = 1;
  localparam int REQ_PFQ = 2;

  localparam int DEF_MAX_HOLD = 16;
  localparam int DEF_TURN     = 1;

  localparam int IDX_W  = 2;
  localparam int HOLD_W = 8;
  localparam int TURN_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  // Single-step modulo wrap; callers never exceed 2*n-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input int v, input int n);
    int r;
    r = v;
    if (r >= n) r = r - n;
    return IDX_W'(r);
  endfunction

endpackage

// File: rtl/ibus_arbiter_rr_pick.sv
// Rotating-priority selector: first unmasked requester at or after ptr.
module rr_pick
  import ibus_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [NREQ-1:0]  elig;
  logic [IDX_W-1:0] idx;

  always_comb begin
    elig   = req & ~mask;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = wrap_idx(int'(ptr) + off, NREQ);
      if (!valid && elig[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/ibus_arbiter.sv
// Round-robin owner arbiter for the shared 16-bit internal bus, with enforced
// idle turnaround between owners and forced revoke of overlong holds.
module ibus_arbiter
  import ibus_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TURN     = DEF_TURN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] owner,
  output logic             bus_busy,
  output logic             hold_err,
  input  logic             err_clr
);

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic [NREQ-1:0]   mask;

  logic [IDX_W-1:0]  winner;
  logic              win_valid;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   owner_oh;
  logic              release_bus;
  logic              revoke;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .mask   (mask),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign win_oh      = NREQ'(1) << winner;
  assign owner_oh    = NREQ'(1) << owner;
  assign release_bus = done[owner] | ~req[owner];
  // A release on the limit cycle wins over the revoke.
  assign revoke      = (state == ST_GRANT) && !release_bus &&
                       (hold_cnt == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      owner    <= '0;
      bus_busy <= 1'b0;
      hold_err <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      mask     <= '0;
    end else begin
      mask <= (mask & req) | (revoke ? owner_oh : '0);

      if (revoke)       hold_err <= 1'b1;
      else if (err_clr) hold_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            gnt      <= win_oh;
            owner    <= winner;
            bus_busy <= 1'b1;
            hold_cnt <= HOLD_W'(1);
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_bus || revoke) begin
            gnt      <= '0;
            bus_busy <= 1'b0;
            ptr      <= wrap_idx(int'(owner) + 1, NREQ);
            turn_cnt <= TURN_W'(1);
            state    <= ST_TURN;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        ST_TURN: begin
          if (turn_cnt == TURN_W'(TURN)) begin
            if (win_valid) begin
              gnt      <= win_oh;
              owner    <= winner;
              bus_busy <= 1'b1;
              hold_cnt <= HOLD_W'(1);
              state    <= ST_GRANT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  assert property (@(posedge clk) disable iff (!rst_n) (state == ST_TURN) |-> (gnt == '0));

endmodule
